// File: rtl/seg7_pkg.sv
// seg7_pkg
//   Shared constants for the 3-digit 7-segment scan driver.
//   Segment patterns are active-high and ordered {dp,g,f,e,d,c,b,a};
//   output polarity is applied by the consumer, not here.
package seg7_pkg;

  localparam int NUM_DIGITS = 3;
  localparam int DIGIT_W    = 4;
  localparam int SEG_W      = 8;

  localparam logic [DIGIT_W-1:0] BLANK_CODE = 4'hF;

  // Digit slot currently being scanned; left digit is shown first.
  typedef enum logic [1:0] {
    SLOT_LEFT  = 2'd0,
    SLOT_MID   = 2'd1,
    SLOT_RIGHT = 2'd2
  } slot_e;

  // Active-high lit-segment patterns, bit order {dp,g,f,e,d,c,b,a}.
  localparam logic [SEG_W-1:0] SEG_0     = 8'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 8'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 8'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 8'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 8'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 8'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 8'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 8'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 8'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 8'h6F;
  localparam logic [SEG_W-1:0] SEG_A     = 8'h77;  // A
  localparam logic [SEG_W-1:0] SEG_B     = 8'h7C;  // b
  localparam logic [SEG_W-1:0] SEG_C     = 8'h39;  // C
  localparam logic [SEG_W-1:0] SEG_D     = 8'h5E;  // d
  localparam logic [SEG_W-1:0] SEG_DASH  = 8'h40;  // code E: '-'
  localparam logic [SEG_W-1:0] SEG_BLANK = 8'h00;  // code F

endpackage

// File: rtl/seg7_decode.sv
// seg7_decode
//   Combinational 4-bit digit code -> active-high segment pattern.
//   Ports:
//     code     in   4  digit code (0-9, A-D letters, E dash, F blank)
//     pattern  out  8  {dp,g,f,e,d,c,b,a}, 1 = lit; dp never lit
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [DIGIT_W-1:0] code,
  output logic [SEG_W-1:0]   pattern
);

  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      4'h0:    pattern = SEG_0;
      4'h1:    pattern = SEG_1;
      4'h2:    pattern = SEG_2;
      4'h3:    pattern = SEG_3;
      4'h4:    pattern = SEG_4;
      4'h5:    pattern = SEG_5;
      4'h6:    pattern = SEG_6;
      4'h7:    pattern = SEG_7;
      4'h8:    pattern = SEG_8;
      4'h9:    pattern = SEG_9;
      4'hA:    pattern = SEG_A;
      4'hB:    pattern = SEG_B;
      4'hC:    pattern = SEG_C;
      4'hD:    pattern = SEG_D;
      4'hE:    pattern = SEG_DASH;
      default: pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed 3-digit 7-segment driver. Scans a latched 12-bit digit
//   word onto shared segment lines, one digit slot of SCAN_DIV cycles at a
//   time, and emits a scroll tick every FRAMES_PER_TICK frames.
//   Ports:
//     clk            in   1   clock
//     rst            in   1   synchronous, active-low reset
//     i_en           in   1   scan enable
//     i_digits       in   12  {left, middle, right} 4-bit digit codes
//     o_an           out  3   digit enables, o_an[0]=left .. o_an[2]=right
//     o_seg          out  8   {dp,g,f,e,d,c,b,a}
//     o_scroll_tick  out  1   one-cycle pulse per FRAMES_PER_TICK frames
//   All outputs are registered: pins show the previous cycle's scan state.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV        = 50000,
  parameter int GUARD           = 16,
  parameter int FRAMES_PER_TICK = 100,
  parameter int SEG_ACTIVE_LOW  = 1,
  parameter int AN_ACTIVE_LOW   = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_en,
  input  logic [11:0] i_digits,
  output logic [2:0]  o_an,
  output logic [7:0]  o_seg,
  output logic        o_scroll_tick
);

  localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam int FC_W  = (FRAMES_PER_TICK > 2) ? $clog2(FRAMES_PER_TICK) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(FRAMES_PER_TICK - 1);

  localparam logic [2:0]       AN_OFF  = (AN_ACTIVE_LOW != 0) ? 3'b111 : 3'b000;
  localparam logic [SEG_W-1:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  slot_e            slot, slot_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [FC_W-1:0]  frame_cnt, frame_cnt_nxt;
  logic [11:0]      frame, frame_nxt;
  logic [2:0]       an_nxt;
  logic [SEG_W-1:0] seg_nxt;
  logic             tick_nxt;

  logic             in_guard;
  logic             slot_end;
  logic             frame_end;
  logic [DIGIT_W-1:0] cur_code;
  logic [SEG_W-1:0]   cur_pattern;
  logic [2:0]         an_onehot;

  // Guard window: leading cycles of each slot with every anode off, so the
  // segment lines settle before the next digit is enabled.
  generate
    if (GUARD > 0) begin : g_guard
      localparam logic [CNT_W-1:0] GUARD_V = CNT_W'(GUARD);
      assign in_guard = (cnt < GUARD_V);
    end else begin : g_no_guard
      assign in_guard = 1'b0;
    end
  endgenerate

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (slot == SLOT_RIGHT);

  always_comb begin
    cur_code  = frame[3:0];
    an_onehot = 3'b100;
    case (slot)
      SLOT_LEFT: begin
        cur_code  = frame[11:8];
        an_onehot = 3'b001;
      end
      SLOT_MID: begin
        cur_code  = frame[7:4];
        an_onehot = 3'b010;
      end
      default: begin
        cur_code  = frame[3:0];
        an_onehot = 3'b100;
      end
    endcase
  end

  seg7_decode u_decode (
    .code    (cur_code),
    .pattern (cur_pattern)
  );

  // Next-state and next-output logic. Disable takes priority over any
  // latch/tick condition falling on the same edge.
  always_comb begin
    cnt_nxt       = cnt;
    slot_nxt      = slot;
    frame_cnt_nxt = frame_cnt;
    frame_nxt     = frame;
    an_nxt        = AN_OFF;
    seg_nxt       = SEG_OFF;
    tick_nxt      = 1'b0;

    if (!i_en) begin
      // While idle the frame tracks the input, so the first frame after
      // enable shows the value present on the last disabled cycle.
      cnt_nxt       = '0;
      slot_nxt      = SLOT_LEFT;
      frame_cnt_nxt = '0;
      frame_nxt     = i_digits;
    end else begin
      if (!in_guard) begin
        an_nxt  = (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
        seg_nxt = (SEG_ACTIVE_LOW != 0) ? ~cur_pattern : cur_pattern;
      end

      if (slot_end) begin
        cnt_nxt = '0;
        case (slot)
          SLOT_LEFT: slot_nxt = SLOT_MID;
          SLOT_MID:  slot_nxt = SLOT_RIGHT;
          default:   slot_nxt = SLOT_LEFT;
        endcase
      end else begin
        cnt_nxt = cnt + 1'b1;
      end

      // Latch only at the frame boundary so a frame never tears.
      if (frame_end) begin
        frame_nxt = i_digits;
        if (frame_cnt == FC_LAST) begin
          frame_cnt_nxt = '0;
          tick_nxt      = 1'b1;
        end else begin
          frame_cnt_nxt = frame_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt           <= '0;
      slot          <= SLOT_LEFT;
      frame_cnt     <= '0;
      frame         <= 12'hFFF;
      o_an          <= AN_OFF;
      o_seg         <= SEG_OFF;
      o_scroll_tick <= 1'b0;
    end else begin
      cnt           <= cnt_nxt;
      slot          <= slot_nxt;
      frame_cnt     <= frame_cnt_nxt;
      frame         <= frame_nxt;
      o_an          <= an_nxt;
      o_seg         <= seg_nxt;
      o_scroll_tick <= tick_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
//   Self-checking bench for seg7_scan_driver (SCAN_DIV=8, GUARD=2,
//   FRAMES_PER_TICK=3, active-low anodes and segments). A behavioural model
//   derived from elapsed enabled time predicts every output cycle; directed
//   checks cover the documented scenarios, then a randomized run follows.
module tb_seg7_scan_driver;

  localparam int SD  = 8;
  localparam int GD  = 2;
  localparam int FPT = 3;
  localparam int FRAME_CYC = 3 * SD;

  logic        clk;
  logic        rst;
  logic        i_en;
  logic [11:0] i_digits;
  logic [2:0]  o_an;
  logic [7:0]  o_seg;
  logic        o_scroll_tick;

  int errors = 0;
  int checks = 0;

  // Model state: enabled cycles elapsed since last enable/reset, and the word on display.
  int          m_t;
  logic [11:0] m_word;
  logic [2:0]  exp_an;
  logic [7:0]  exp_seg;
  logic        exp_tick;

  logic [31:0] exp_q[$];

  seg7_scan_driver #(
    .SCAN_DIV        (SD),
    .GUARD           (GD),
    .FRAMES_PER_TICK (FPT),
    .SEG_ACTIVE_LOW  (1),
    .AN_ACTIVE_LOW   (1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_en          (i_en),
    .i_digits      (i_digits),
    .o_an          (o_an),
    .o_seg         (o_seg),
    .o_scroll_tick (o_scroll_tick)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Glyphs as the letters of the lit segments.
  function automatic string glyph(input logic [3:0] c);
    case (c)
      4'h0: return "abcdef";
      4'h1: return "bc";
      4'h2: return "abdeg";
      4'h3: return "abcdg";
      4'h4: return "bcfg";
      4'h5: return "acdfg";
      4'h6: return "acdefg";
      4'h7: return "abc";
      4'h8: return "abcdefg";
      4'h9: return "abcdfg";
      4'hA: return "abcefg";
      4'hB: return "cdefg";
      4'hC: return "adef";
      4'hD: return "bcdeg";
      4'hE: return "g";
      default: return "";
    endcase
  endfunction

  function automatic logic [7:0] lit_mask(input logic [3:0] c);
    string s;
    logic [7:0] m;
    m = 8'h00;
    s = glyph(c);
    for (int i = 0; i < s.len(); i++) m[int'(s[i]) - 97] = 1'b1;
    return m;
  endfunction

  // Predict the registered outputs produced by the coming edge.
  task automatic model_edge();
    int slot;
    int pos;
    logic [3:0] code;
    if (!rst) begin
      m_t = 0; m_word = 12'hFFF;
      exp_an = 3'b111; exp_seg = 8'hFF; exp_tick = 1'b0;
    end else if (!i_en) begin
      m_t = 0; m_word = i_digits;
      exp_an = 3'b111; exp_seg = 8'hFF; exp_tick = 1'b0;
    end else begin
      slot = (m_t / SD) % 3;
      pos  = m_t % SD;
      exp_tick = 1'b0;
      if (pos < GD) begin
        exp_an = 3'b111; exp_seg = 8'hFF;
      end else begin
        exp_an = 3'b111;
        exp_an[slot] = 1'b0;
        code = m_word[4*(2-slot) +: 4];
        exp_seg = ~lit_mask(code);
      end
      if (m_t % FRAME_CYC == FRAME_CYC - 1) begin
        m_word = i_digits;
        if (((m_t + 1) / FRAME_CYC) % FPT == 0) exp_tick = 1'b1;
      end
      m_t++;
    end
  endtask

  // Driver: one clock; model advances on the edge, outputs checked on the falling edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      checks++;
      assert (o_an === exp_an) else begin
        errors++;
        $error("FAIL an t=%0t got=%b exp=%b", $time, o_an, exp_an);
      end
      checks++;
      assert (o_seg === exp_seg) else begin
        errors++;
        $error("FAIL seg t=%0t got=%h exp=%h", $time, o_seg, exp_seg);
      end
      checks++;
      assert (o_scroll_tick === exp_tick) else begin
        errors++;
        $error("FAIL tick t=%0t got=%b exp=%b", $time, o_scroll_tick, exp_tick);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    int ticks;
    int last_tick;
    int r;

    rst = 1'b0; i_en = 1'b0; i_digits = 12'h000;

    // 1. Reset held 3 cycles, release with scan disabled.
    step(3);
    check_val("reset_an", {29'd0, o_an}, 32'h7);
    check_val("reset_seg", {24'd0, o_seg}, 32'hFF);
    rst = 1'b1;
    step(4);
    check_val("idle_an", {29'd0, o_an}, 32'h7);

    // 2. Enable with 1,2,blank.
    i_digits = 12'h12F;
    step(1);
    i_en = 1'b1;
    step(2);
    check_val("guard_an", {29'd0, o_an}, 32'h7);
    step(1);
    check_val("slot0_an", {29'd0, o_an}, 32'h6);
    check_val("slot0_seg", {24'd0, o_seg}, 32'hF9);
    step(8);
    check_val("slot1_an", {29'd0, o_an}, 32'h5);
    check_val("slot1_seg", {24'd0, o_seg}, 32'hA4);

    // 3. Change mid-slot-1: current frame unaffected, next frame shows 3,4,5.
    i_digits = 12'h345;
    step(8);
    check_val("slot2_an", {29'd0, o_an}, 32'h3);
    check_val("slot2_seg", {24'd0, o_seg}, 32'hFF);
    step(8);
    check_val("next_frame_seg", {24'd0, o_seg}, 32'hB0);

    // 4. Nine frames: three single-cycle ticks, three frames apart.
    ticks = 0;
    last_tick = -1;
    exp_q.push_back(32'(FPT * FRAME_CYC));
    exp_q.push_back(32'(FPT * FRAME_CYC));
    for (int i = 0; i < 9 * FRAME_CYC; i++) begin
      step(1);
      if (o_scroll_tick === 1'b1) begin
        ticks++;
        if (last_tick >= 0 && exp_q.size() > 0) check_val("tick_gap", 32'(i - last_tick), exp_q.pop_front());
        last_tick = i;
      end
    end
    check_val("tick_count", 32'(ticks), 32'd3);

    // 5. Reset mid-slot-1, then blank until the first latch.
    step(10);
    rst = 1'b0;
    i_digits = 12'h789;
    step(1);
    check_val("midreset_an", {29'd0, o_an}, 32'h7);
    check_val("midreset_seg", {24'd0, o_seg}, 32'hFF);
    step(1);
    rst = 1'b1;
    step(3);
    check_val("post_reset_an", {29'd0, o_an}, 32'h6);
    check_val("post_reset_blank", {24'd0, o_seg}, 32'hFF);
    step(20);
    step(6);
    check_val("post_latch_seg", {24'd0, o_seg}, 32'hF8);

    // 6. Disable exactly on the tick-condition edge.
    step(42);
    i_en = 1'b0;
    step(1);
    check_val("dis_tick", {31'd0, o_scroll_tick}, 32'd0);
    check_val("dis_an", {29'd0, o_an}, 32'h7);
    step(2);
    i_digits = 12'hABC;
    step(1);
    i_en = 1'b1;
    step(2);
    check_val("reen_guard_an", {29'd0, o_an}, 32'h7);
    step(1);
    check_val("reen_an", {29'd0, o_an}, 32'h6);
    check_val("reen_seg", {24'd0, o_seg}, 32'h88);

    // Randomized run against the model.
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 10) i_digits = 12'($urandom_range(0, 4095));
      if ($urandom_range(0, 299) == 0) i_en = ~i_en;
      rst = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
      step(1);
    end
    rst = 1'b1;
    i_en = 1'b1;
    step(4 * FRAME_CYC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
